regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
Parametrised multi-port integer register file for the pipelined core. It provides READ_PORTS combinational read ports with same-cycle write-to-read bypass and WRITE_PORTS writeback ports. A per-register busy scoreboard is set at issue and cleared at writeback. Decode uses the busy flags for hazard stalls. The block sits between decode/issue and the writeback stage, and replaces the single-write, no-reset register file.

Parameters:
DATA_WIDTH, 32, register width in bits
REG_COUNT, 32, number of architectural registers (power of two)
IDX_WIDTH, 5, register index width, equal to log2(REG_COUNT)
READ_PORTS, 2, number of read ports (1..4)
WRITE_PORTS, 2, number of writeback ports (1..2)
ZERO_REG, 1, 1 means register 0 is hardwired to zero and never marked busy

Ports:
clk  in  1  clock; all state updates on the rising edge
rstn  in  1  asynchronous active-low reset
readAddr  in  READ_PORTS*IDX_WIDTH  read indices; port p is bits [p*IDX_WIDTH +: IDX_WIDTH]
readData  out  READ_PORTS*DATA_WIDTH  read data, same packing as readAddr
readBusy  out  READ_PORTS  1 means the addressed register has a producer pending (after bypass)
writeEnable  in  WRITE_PORTS  per-port write strobe
writeAddr  in  WRITE_PORTS*IDX_WIDTH  per-port write index
writeData  in  WRITE_PORTS*DATA_WIDTH  per-port write data
issueValid  in  1  an instruction with destination issueRd issues this cycle
issueRd  in  IDX_WIDTH  destination register of the issuing instruction
flush  in  1  pipeline flush; clears all busy bits
busyCount  out  IDX_WIDTH+1  number of registers currently busy

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous and active-low.
- Reset (rstn=0): all registers read 0, all busy bits 0, busyCount=0, immediately and without waiting for a clock edge. readData then reflects 0 except where a write is being bypassed combinationally.
- Write: on the rising edge, for each port w with writeEnable[w]=1, reg[writeAddr[w]] <= writeData[w].
  - With ZERO_REG=1, writes to index 0 are discarded.
  - If both ports write the same index in one cycle, port WRITE_PORTS-1 wins.
- Read: fully combinational, zero latency.
  - Priority order: (1) index 0 with ZERO_REG=1 returns 0; (2) a same-cycle enabled write to the same index returns that write's data, highest write port winning; (3) otherwise the stored value.
- Scoreboard: on the rising edge:
  - writeEnable[w] clears busy[writeAddr[w]].
  - issueValid sets busy[issueRd] (ignored for index 0 when ZERO_REG=1).
  - When issue and writeback target the same index in the same cycle, issue wins and busy stays 1, because the new producer supersedes.
  - flush clears every busy bit and overrides issue in that cycle. Register contents are unaffected and a same-cycle write still commits.
- readBusy[p] = busy[readAddr[p]] AND NOT (any same-cycle write to readAddr[p]). A bypassed operand is therefore never reported busy. Index 0 is never busy.
- busyCount: registered; equals the popcount of the busy vector after each edge. An increment and a decrement in the same cycle net to zero. Range is 0..REG_COUNT.
- Usage constraint (guaranteed by issue logic, not checked): at most one outstanding producer per register. Issue stalls while readBusy is set on its rd.
- Writes to registers that are not busy are legal and leave busy at 0.
- Reset asserted mid-operation: all state clears at once; writes and issues in flight are lost.

Test Plan:
- Reset then read all indices on every port -> readData=0, readBusy=0, busyCount=0. Write x5=0xDEADBEEF, next cycle read x5 on port 1 -> 0xDEADBEEF.
- Write x0=0x1234 with issueValid/issueRd=0 -> x0 reads 0, readBusy[0]=0, busyCount stays 0.
- Port0 writes x7=0x11 while port1 writes x7=0x22 in the same cycle; port0 reads x7 that cycle -> 0x22 (bypass). Next cycle -> 0x22 from storage.
- Issue rd=x3 -> readBusy=1 for x3, busyCount=1. Writeback x3=0xA5 later: that cycle readData=0xA5, readBusy=0; next cycle busyCount=0. Repeat with issue x3 and writeback x3 in the same cycle -> busy stays 1, busyCount unchanged.
- Issue x1, x2, x4 on consecutive cycles -> busyCount 1,2,3. Assert flush together with issue x6 -> busyCount=0 next cycle, x6 not busy.
- Drop rstn asynchronously mid-cycle with x9 busy holding 0x55 -> x9 reads 0 and busy clears before the next clk edge. After release, a write of x9=0x66 followed by a read returns 0x66.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with a per-register busy scoreboard.
// Reads are combinational with same-cycle write bypass; busy bits are set
// at issue, cleared at writeback or flush, and their popcount is registered.
module regfile_scoreboard #(
  parameter int DATA_WIDTH  = 32,
  parameter int REG_COUNT   = 32,
  parameter int IDX_WIDTH   = 5,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2,
  parameter int ZERO_REG    = 1
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [READ_PORTS*IDX_WIDTH-1:0]   readAddr,
  output logic [READ_PORTS*DATA_WIDTH-1:0]  readData,
  output logic [READ_PORTS-1:0]             readBusy,
  input  logic [WRITE_PORTS-1:0]            writeEnable,
  input  logic [WRITE_PORTS*IDX_WIDTH-1:0]  writeAddr,
  input  logic [WRITE_PORTS*DATA_WIDTH-1:0] writeData,
  input  logic                              issueValid,
  input  logic [IDX_WIDTH-1:0]              issueRd,
  input  logic                              flush,
  output logic [IDX_WIDTH:0]                busyCount
);

  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
  logic [REG_COUNT-1:0]  busy_q;
  logic [REG_COUNT-1:0]  busy_d;
  logic [IDX_WIDTH:0]    busy_count_q;
  logic [IDX_WIDTH:0]    busy_count_d;

  // Number of set bits in the busy vector.
  function automatic logic [IDX_WIDTH:0] popcount(input logic [REG_COUNT-1:0] v);
    logic [IDX_WIDTH:0] c;
    c = {(IDX_WIDTH+1){1'b0}};
    for (int i = 0; i < REG_COUNT; i++) begin
      c = c + {{IDX_WIDTH{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // True when idx names the hardwired zero register.
  function automatic logic is_zero_reg(input logic [IDX_WIDTH-1:0] idx);
    return (ZERO_REG == 1) && (idx == {IDX_WIDTH{1'b0}});
  endfunction

  // Next register contents: ascending port order lets the highest port win a collision.
  always_comb begin
    for (int r = 0; r < REG_COUNT; r++) begin
      regs_d[r] = regs_q[r];
    end
    for (int w = 0; w < WRITE_PORTS; w++) begin
      if (writeEnable[w] && !is_zero_reg(writeAddr[w*IDX_WIDTH +: IDX_WIDTH])) begin
        regs_d[writeAddr[w*IDX_WIDTH +: IDX_WIDTH]] = writeData[w*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        regs_d[0] = regs_d[0];
      end
    end
  end

  // Next busy vector: writebacks clear, then issue sets (new producer supersedes), flush clears all.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < WRITE_PORTS; w++) begin
      if (writeEnable[w]) begin
        busy_d[writeAddr[w*IDX_WIDTH +: IDX_WIDTH]] = 1'b0;
      end else begin
        busy_d = busy_d;
      end
    end
    if (flush) begin
      busy_d = {REG_COUNT{1'b0}};
    end else if (issueValid && !is_zero_reg(issueRd)) begin
      busy_d[issueRd] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    if (ZERO_REG == 1) begin
      busy_d[0] = 1'b0;
    end else begin
      busy_d[0] = busy_d[0];
    end
    busy_count_d = popcount(busy_d);
  end

  // Register file storage, cleared asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        regs_q[r] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      for (int r = 0; r < REG_COUNT; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  // Scoreboard busy bits and their registered count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q       <= {REG_COUNT{1'b0}};
      busy_count_q <= {(IDX_WIDTH+1){1'b0}};
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  // Combinational read ports: zero register, then write bypass, then storage.
  always_comb begin
    readData = {(READ_PORTS*DATA_WIDTH){1'b0}};
    readBusy = {READ_PORTS{1'b0}};
    for (int p = 0; p < READ_PORTS; p++) begin
      readData[p*DATA_WIDTH +: DATA_WIDTH] = regs_q[readAddr[p*IDX_WIDTH +: IDX_WIDTH]];
      readBusy[p] = busy_q[readAddr[p*IDX_WIDTH +: IDX_WIDTH]];
      for (int w = 0; w < WRITE_PORTS; w++) begin
        if (writeEnable[w] &&
            (writeAddr[w*IDX_WIDTH +: IDX_WIDTH] == readAddr[p*IDX_WIDTH +: IDX_WIDTH])) begin
          readData[p*DATA_WIDTH +: DATA_WIDTH] = writeData[w*DATA_WIDTH +: DATA_WIDTH];
          readBusy[p] = 1'b0;
        end else begin
          readBusy[p] = readBusy[p];
        end
      end
      if (is_zero_reg(readAddr[p*IDX_WIDTH +: IDX_WIDTH])) begin
        readData[p*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
        readBusy[p] = 1'b0;
      end else begin
        readBusy[p] = readBusy[p];
      end
    end
  end

  assign busyCount = busy_count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: a driver pushes expected outputs
// from a behavioural model; a negedge monitor pops and compares.
module tb_regfile_scoreboard;
  localparam int DW = 32;
  localparam int RC = 32;
  localparam int IW = 5;
  localparam int RP = 2;
  localparam int WP = 2;

  logic                clk = 1'b0;
  logic                rstn;
  logic [RP*IW-1:0]    readAddr;
  logic [RP*DW-1:0]    readData;
  logic [RP-1:0]       readBusy;
  logic [WP-1:0]       writeEnable;
  logic [WP*IW-1:0]    writeAddr;
  logic [WP*DW-1:0]    writeData;
  logic                issueValid;
  logic [IW-1:0]       issueRd;
  logic                flush;
  logic [IW:0]         busyCount;

  regfile_scoreboard #(
    .DATA_WIDTH(DW), .REG_COUNT(RC), .IDX_WIDTH(IW),
    .READ_PORTS(RP), .WRITE_PORTS(WP), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rstn(rstn), .readAddr(readAddr), .readData(readData),
    .readBusy(readBusy), .writeEnable(writeEnable), .writeAddr(writeAddr),
    .writeData(writeData), .issueValid(issueValid), .issueRd(issueRd),
    .flush(flush), .busyCount(busyCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RP*DW-1:0] rd;
    logic [RP-1:0]    rb;
    logic [IW:0]      bc;
  } exp_t;

  exp_t        exp_q[$];
  logic [DW-1:0] m_mem [RC];
  bit            m_busy [RC];
  int            n_vec  = 0;
  int            n_miss = 0;

  task automatic model_clear();
    for (int r = 0; r < RC; r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  // Expected outputs for the inputs currently driven and the current model state.
  task automatic push_expect();
    exp_t e;
    int   cnt;
    int   idx;
    e.rd = '0;
    e.rb = '0;
    for (int p = 0; p < RP; p++) begin
      logic [DW-1:0] d;
      bit            b;
      idx = int'(readAddr[p*IW +: IW]);
      d = m_mem[idx];
      b = m_busy[idx];
      for (int w = 0; w < WP; w++) begin
        if (writeEnable[w] && int'(writeAddr[w*IW +: IW]) == idx) begin
          d = writeData[w*DW +: DW];
          b = 1'b0;
        end
      end
      if (idx == 0) begin
        d = '0;
        b = 1'b0;
      end
      e.rd[p*DW +: DW] = d;
      e.rb[p] = b;
    end
    cnt = 0;
    for (int r = 0; r < RC; r++) cnt += int'(m_busy[r]);
    e.bc = cnt[IW:0];
    exp_q.push_back(e);
  endtask

  // Apply the rules of one rising edge to the model.
  task automatic model_edge();
    int a;
    for (int w = 0; w < WP; w++) begin
      if (writeEnable[w]) begin
        a = int'(writeAddr[w*IW +: IW]);
        if (a != 0) m_mem[a] = writeData[w*DW +: DW];
        m_busy[a] = 1'b0;
      end
    end
    if (flush) begin
      for (int r = 0; r < RC; r++) m_busy[r] = 1'b0;
    end else if (issueValid && issueRd != '0) begin
      m_busy[int'(issueRd)] = 1'b1;
    end
  endtask

  task automatic cyc(input logic [IW-1:0] ra0, input logic [IW-1:0] ra1,
                     input logic [1:0] we, input logic [IW-1:0] wa0, input logic [IW-1:0] wa1,
                     input logic [DW-1:0] wd0, input logic [DW-1:0] wd1,
                     input logic iv, input logic [IW-1:0] ird, input logic fl);
    @(posedge clk);
    #1;
    readAddr    = {ra1, ra0};
    writeEnable = we;
    writeAddr   = {wa1, wa0};
    writeData   = {wd1, wd0};
    issueValid  = iv;
    issueRd     = ird;
    flush       = fl;
    push_expect();
    model_edge();
  endtask

  task automatic idle_read(input logic [IW-1:0] ra0, input logic [IW-1:0] ra1);
    cyc(ra0, ra1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
  endtask

  // Drop reset between edges with x9 addressed; outputs must clear before the next edge.
  task automatic async_reset();
    @(posedge clk);
    #1;
    readAddr    = {5'd9, 5'd9};
    writeEnable = 2'b00;
    issueValid  = 1'b0;
    flush       = 1'b0;
    #1;
    rstn = 1'b0;
    model_clear();
    push_expect();
    @(negedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Monitor: compare DUT outputs against the oldest pending expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      for (int p = 0; p < RP; p++) begin
        n_vec++;
        if (readData[p*DW +: DW] !== e.rd[p*DW +: DW]) begin
          n_miss++;
          $display("FAIL readData[%0d] addr=%0d actual=%h required=%h t=%0t",
                   p, readAddr[p*IW +: IW], readData[p*DW +: DW], e.rd[p*DW +: DW], $time);
        end
      end
      n_vec++;
      if (readBusy !== e.rb) begin
        n_miss++;
        $display("FAIL readBusy actual=%b required=%b t=%0t", readBusy, e.rb, $time);
      end
      n_vec++;
      if (busyCount !== e.bc) begin
        n_miss++;
        $display("FAIL busyCount actual=%0d required=%0d t=%0t", busyCount, e.bc, $time);
      end
    end
  end

  initial begin
    logic [IW-1:0] ra0, ra1, wa0, wa1, ird;
    logic [1:0]    we;
    logic          iv, fl;
    rstn        = 1'b0;
    readAddr    = '0;
    writeEnable = '0;
    writeAddr   = '0;
    writeData   = '0;
    issueValid  = 1'b0;
    issueRd     = '0;
    flush       = 1'b0;
    model_clear();
    #2;
    readAddr = {5'd5, 5'd3};
    push_expect();
    #10;
    rstn = 1'b1;

    // Read every index on both ports after reset.
    for (int i = 0; i < RC; i++) idle_read(5'(i), 5'(RC - 1 - i));
    // Write x5 then read it back on port 1.
    cyc(5'd1, 5'd2, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 5'd0, 1'b0);
    idle_read(5'd0, 5'd5);
    // Writes and issue to x0 are discarded.
    cyc(5'd0, 5'd0, 2'b01, 5'd0, 5'd0, 32'h1234, 32'h0, 1'b1, 5'd0, 1'b0);
    idle_read(5'd0, 5'd0);
    // Same-index collision: port 1 wins, also through bypass.
    cyc(5'd7, 5'd7, 2'b11, 5'd7, 5'd7, 32'h11, 32'h22, 1'b0, 5'd0, 1'b0);
    idle_read(5'd7, 5'd7);
    // Issue then writeback of x3.
    cyc(5'd3, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd3, 1'b0);
    idle_read(5'd3, 5'd3);
    cyc(5'd3, 5'd3, 2'b10, 5'd0, 5'd3, 32'h0, 32'hA5, 1'b0, 5'd0, 1'b0);
    idle_read(5'd3, 5'd3);
    // Issue and writeback of x3 together: issue wins.
    cyc(5'd3, 5'd0, 2'b01, 5'd3, 5'd0, 32'hB6, 32'h0, 1'b1, 5'd3, 1'b0);
    idle_read(5'd3, 5'd3);
    cyc(5'd3, 5'd3, 2'b01, 5'd3, 5'd0, 32'hC7, 32'h0, 1'b0, 5'd0, 1'b0);
    // Build up busy count then flush with a competing issue.
    cyc(5'd1, 5'd2, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd1, 1'b0);
    cyc(5'd1, 5'd2, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd2, 1'b0);
    cyc(5'd4, 5'd2, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd4, 1'b0);
    cyc(5'd4, 5'd6, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd6, 1'b1);
    idle_read(5'd6, 5'd4);
    // Async reset with x9 busy holding 0x55, then reuse x9.
    cyc(5'd9, 5'd9, 2'b01, 5'd9, 5'd0, 32'h55, 32'h0, 1'b1, 5'd9, 1'b0);
    idle_read(5'd9, 5'd9);
    async_reset();
    cyc(5'd9, 5'd1, 2'b01, 5'd9, 5'd0, 32'h66, 32'h0, 1'b0, 5'd0, 1'b0);
    idle_read(5'd1, 5'd9);

    // Randomised traffic, biased toward a few indices to force collisions.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        ra0 = 5'($urandom_range(0, 7)); ra1 = 5'($urandom_range(0, 7));
        wa0 = 5'($urandom_range(0, 7)); wa1 = 5'($urandom_range(0, 7));
        ird = 5'($urandom_range(0, 7));
      end else begin
        ra0 = 5'($urandom); ra1 = 5'($urandom);
        wa0 = 5'($urandom); wa1 = 5'($urandom);
        ird = 5'($urandom);
      end
      we = 2'($urandom);
      iv = ($urandom_range(0, 1) == 1) && !m_busy[int'(ird)];
      fl = ($urandom_range(0, 19) == 0);
      cyc(ra0, ra1, we, wa0, wa1, $urandom, $urandom, iv, ird, fl);
      if (n == 300) async_reset();
    end
    idle_read(5'd0, 5'd1);

    // Drain: every expectation must be consumed within a few cycles.
    for (int k = 0; k < 8 && exp_q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
